// File: rtl/mix_pkg.sv
// mix_pkg: constants and types shared by the mix encoder and decoder
// Provides the word count, block type, per-word multipliers K, offsets C and their mod-2^32 inverses KINV.
package mix_pkg;
  localparam int WORDS = 8;
  typedef logic [WORDS-1:0][31:0] block_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dec_state_t;
  // Newton iteration for an odd k: x=k is exact to 3 bits, each step doubles that (3,6,12,24,48)
  function automatic logic [31:0] inv32(input logic [31:0] k);
    logic [31:0] x;
    x = k;
    for (int n = 0; n < 4; n++) x = x * (32'd2 - k * x);
    return x;
  endfunction
  localparam logic [31:0] K [WORDS] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam logic [31:0] C [WORDS] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
  localparam logic [31:0] KINV [WORDS] = '{inv32(32'd3), inv32(32'd5), inv32(32'd7), inv32(32'd11),
                                           inv32(32'd13), inv32(32'd17), inv32(32'd19), inv32(32'd23)};
endpackage

// File: rtl/mix_dec_if.sv
// mix_dec_if: valid/ready block bus into and out of the decoder
// in_valid/in_ready/in_data: encoded block in; out_valid/out_ready/out_data: decoded block out.
interface mix_dec_if;
  import mix_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  block_t in_data, out_data;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/mix_dec_stage.sv
// mix_dec_stage: one combinational inverse stage on a block
// stage: 0=C', 1=B', 2=A'; d: block before the stage; q: block after it.
module mix_dec_stage import mix_pkg::*; (
  input  logic [1:0] stage,
  input  block_t     d,
  output block_t     q
);
  // B' and A' update in place so each step sees the words already rewritten before it
  always_comb begin
    q = d;
    if (stage == 2'd0)
      for (int i = 0; i < WORDS; i++) q[3'(i)] = (q[3'(i)] - C[i]) * KINV[i];
    else if (stage == 2'd1)
      for (int i = WORDS - 1; i >= 0; i--) q[3'(i)] = q[3'(i)] ^ (q[3'(i + 3)] << 16);
    else
      for (int i = WORDS - 1; i >= 0; i--) q[3'(i)] = q[3'(i)] - q[3'(i + 7)] + q[3'(i + 6)];
  end
endmodule

// File: rtl/mix_dec.sv
// mix_dec: iterative inverse-mixing decoder, one stage per clock, ROUNDS rounds per block
// clk: clock; rst_n: async active-low reset; bus: slave side of the in/out valid-ready block handshake.
module mix_dec import mix_pkg::*; #(
  parameter int ROUNDS = 4
) (
  input logic      clk,
  input logic      rst_n,
  mix_dec_if.slave bus
);
  dec_state_t state, nxt;
  logic [1:0] stage;
  logic [3:0] round;
  block_t data, stg_q;
  logic accept, last;
  mix_dec_stage u_stage (.stage(stage), .d(data), .q(stg_q));
  // in_ready is gated by rst_n so it stays low for the whole time reset is held
  always_comb begin
    bus.in_ready = rst_n && state == IDLE;
    bus.out_valid = state == DONE;
    bus.out_data = data;
    accept = state == IDLE && bus.in_valid;
    last = state == RUN && stage == 2'd2 && round == 4'(ROUNDS - 1);
    nxt = state == IDLE ? (accept ? RUN : IDLE) :
          state == RUN  ? (last ? DONE : RUN) :
          (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      stage <= '0;
      round <= '0;
    end else if (accept) begin
      data <= bus.in_data;
      stage <= '0;
      round <= '0;
    end else if (state == RUN) begin
      data <= stg_q;
      stage <= stage == 2'd2 ? 2'd0 : stage + 2'd1;
      round <= stage == 2'd2 ? round + 4'd1 : round;
    end
endmodule

// File: doc/mix_dec.md
MIX_DEC -- requirements
Module: mix_dec

Interface
REQ-001 SHALL have parameter ROUNDS, default 4: number of inverse mixing rounds applied per block (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1: in_data holds an encoded block.
REQ-005 SHALL have port in_ready, output, 1: block accepts a new input.
REQ-006 SHALL have port in_data, input, 256: eight 32-bit words; word i at bits [32i+31:32i].
REQ-007 SHALL have port out_valid, output, 1: out_data holds a decoded block.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-009 SHALL have port out_data, output, 256: decoded words, same packing as in_data.

Function
REQ-010 SHALL invert the forward round F = A, then B, then C, with all index arithmetic mod 8 and all arithmetic mod 2^32:
- A: for i=0..7 in order, w[i] = w[i] + w[i-1] - w[i-2].
- B: for i=0..7 in order, w[i] = w[i] ^ (w[i+3] << 16).
- C: for each i, w[i] = w[i]*K[i] + C[i].
REQ-011 SHALL implement inverse round R = C', then B', then A':
- C': w[i] = (w[i] - C[i]) * KINV[i].
- B': for i=7 down to 0, w[i] = w[i] ^ (w[i+3] << 16).
- A': for i=7 down to 0, w[i] = w[i] - w[i-1] + w[i-2].
Within B' and A', each word update SHALL see the already-updated values of earlier steps in the same stage.
REQ-012 SHALL apply exactly one stage (C', B' or A') per clock, so a block needs 3*ROUNDS compute cycles.
REQ-013 SHALL use FSM states IDLE, RUN and DONE:
- IDLE->RUN on in_valid&&in_ready, capturing in_data.
- RUN->DONE after the final A' of round ROUNDS.
- DONE->IDLE on out_valid&&out_ready.
REQ-014 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-015 SHALL produce a first-accepted-to-out_valid latency of exactly 3*ROUNDS+1 cycles.
REQ-016 SHALL hold out_data stable while out_valid=1 and out_ready=0 for any number of cycles.
REQ-017 SHALL ignore in_valid and in_data while in RUN or DONE.
REQ-018 SHALL track position with a 2-bit stage counter (0=C', 1=B', 2=A', wrapping 2->0) and a 4-bit round counter; both SHALL clear on acceptance.
REQ-019 SHALL allow only one handshake per cycle: in DONE, out_ready=1 with in_valid=1 completes the output only, and the new input is accepted no earlier than the following cycle.

Reset
REQ-020 SHALL, on rst_n=0, asynchronously force: state=IDLE, in_ready=0 while rst_n is low, out_valid=0, out_data=0, and both counters=0.
REQ-021 SHALL discard any in-progress block on reset mid-RUN or mid-DONE, with no output produced for it.
REQ-022 SHALL raise in_ready in the first cycle after rst_n deasserts.

Structure
REQ-023 SHALL take K, C, KINV and the word count (8) from shared package mix_pkg, which the forward encoder also uses.
- K = {3,5,7,11,13,17,19,23}.
- C = {3,5,7,11,13,17,19,23}.
- KINV[i] is the mod-2^32 inverse of K[i], so K*KINV = 1.
REQ-024 SHALL place the three stage functions in one combinational sub-module mix_dec_stage, selected by the stage counter.

Verification
REQ-025 SHALL cover round trip: encode {0,1,..,7} with F applied ROUNDS times, feed the result -> out_data = {0,1,..,7}.
REQ-026 SHALL cover latency: in_valid accepted at cycle 0 with ROUNDS=4 -> out_valid rises at cycle 13.
REQ-027 SHALL cover backpressure: out_ready held low 5 cycles after out_valid -> out_data unchanged, in_ready=0 throughout.
REQ-028 SHALL cover reset mid-RUN: rst_n pulsed at cycle 6 -> out_valid never asserts for that block, and in_ready=1 one cycle after release.
REQ-029 SHALL cover back-to-back traffic: 100 random blocks with in_valid constantly high and random out_ready -> each output equals the golden-model inverse, in order, with none lost or duplicated.
REQ-030 SHALL cover the single-stage check: ROUNDS=1 with input all 0xFFFFFFFF -> out_data matches the golden model, and word 0 = 0xFFFFFFFF only if the model says so (the bench SHALL compare all 8 words).
